// File: rtl/pdm_decimation_chain_if.sv
// PDM bit input and the three decimated PCM outputs of one microphone channel.
interface pdm_decimation_chain_if;
  logic               pdm_in;
  logic signed [15:0] cic_out;
  logic               cic_valid;
  logic signed [16:0] hb1_out;
  logic               hb1_valid;
  logic signed [47:0] hb2_out;
  logic               hb2_valid;

  modport master (
    output pdm_in,
    input  cic_out, cic_valid, hb1_out, hb1_valid, hb2_out, hb2_valid
  );

  modport slave (
    input  pdm_in,
    output cic_out, cic_valid, hb1_out, hb1_valid, hb2_out, hb2_valid
  );
endinterface

// File: rtl/pdm_decimation_chain.sv
// Single-channel PDM to PCM decimator: 4th-order CIC (R=16) followed by two
// decimate-by-2 halfband filters, all paced by clock-enable strobes.
module pdm_decimation_chain #(
  parameter int CIC_ORDER = 4,
  parameter int CIC_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  pdm_decimation_chain_if.slave bus
);

  logic [3:0]         cnt_q;
  logic [CIC_W-1:0]   integ_q   [CIC_ORDER];
  logic [CIC_W-1:0]   integ_d   [CIC_ORDER];
  logic [CIC_W-1:0]   combDly_q [CIC_ORDER];
  logic [CIC_W-1:0]   combStage [CIC_ORDER+1];
  logic               cicStrobe;
  logic signed [15:0] cicOut_q, cicOut_d;
  logic               cicUpd_q, cicValid_q;

  logic signed [15:0] hb1Dly_q [6];
  logic               p1_q;
  logic signed [23:0] hb1Acc, hb1Shr;
  logic signed [16:0] hb1Out_q, hb1Out_d;
  logic               hb1Upd_q, hb1Valid_q;

  logic signed [16:0] hb2Dly_q [10];
  logic               p2_q;
  logic signed [31:0] hb2Pair0, hb2Pair2, hb2Pair4, hb2Mid, hb2Acc;
  logic signed [47:0] hb2Out_q;
  logic               hb2Upd_q, hb2Valid_q;

  function automatic logic signed [23:0] ext16(input logic signed [15:0] v);
    return {{8{v[15]}}, v};
  endfunction

  function automatic logic signed [31:0] ext17(input logic signed [16:0] v);
    return {{15{v[16]}}, v};
  endfunction

  assign cicStrobe = (cnt_q == 4'hF);

  // Integrators chain through the freshly updated previous stage; wrap is intended.
  always_comb begin
    integ_d[0] = integ_q[0] + CIC_W'(bus.pdm_in);
    for (int k = 1; k < CIC_ORDER; k++) integ_d[k] = integ_q[k] + integ_d[k-1];
    combStage[0] = integ_d[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) combStage[k+1] = combStage[k] - combDly_q[k];
    if (combStage[CIC_ORDER] > CIC_W'(65535)) cicOut_d = 16'sh7FFF;
    else cicOut_d = {~combStage[CIC_ORDER][15], combStage[CIC_ORDER][14:0]};
  end

  // Taps are the post-shift line: x0 is the incoming sample, xk the old x(k-1).
  always_comb begin
    hb1Acc = (ext16(hb1Dly_q[1]) <<< 3) + ext16(hb1Dly_q[1])
           + (ext16(hb1Dly_q[2]) <<< 4)
           + (ext16(hb1Dly_q[3]) <<< 3) + ext16(hb1Dly_q[3])
           - ext16(cicOut_q) - ext16(hb1Dly_q[5]);
    hb1Shr = hb1Acc >>> 4;
    if (hb1Shr > 24'sd65535)       hb1Out_d = 17'sh0FFFF;
    else if (hb1Shr < -24'sd65536) hb1Out_d = 17'sh10000;
    else                           hb1Out_d = hb1Shr[16:0];
  end

  always_comb begin
    hb2Pair0 = ext17(hb1Out_q) + ext17(hb2Dly_q[9]);
    hb2Pair2 = ext17(hb2Dly_q[1]) + ext17(hb2Dly_q[7]);
    hb2Pair4 = ext17(hb2Dly_q[3]) + ext17(hb2Dly_q[5]);
    hb2Mid   = ext17(hb2Dly_q[4]);
    hb2Acc   = (hb2Pair0 <<< 1) + hb2Pair0
             - ((hb2Pair2 <<< 4) + (hb2Pair2 <<< 3) + hb2Pair2)
             + (hb2Pair4 <<< 7) + (hb2Pair4 <<< 4) + (hb2Pair4 <<< 2) + (hb2Pair4 <<< 1)
             + (hb2Mid <<< 8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      cicOut_q   <= '0;
      cicUpd_q   <= 1'b0;
      cicValid_q <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ_q[k]   <= '0;
        combDly_q[k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_q + 4'd1;
      integ_q    <= integ_d;
      cicUpd_q   <= cicStrobe;
      cicValid_q <= cicUpd_q;
      if (cicStrobe) begin
        cicOut_q <= cicOut_d;
        for (int k = 0; k < CIC_ORDER; k++) combDly_q[k] <= combStage[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) hb1Dly_q[k] <= '0;
      p1_q       <= 1'b0;
      hb1Out_q   <= '0;
      hb1Upd_q   <= 1'b0;
      hb1Valid_q <= 1'b0;
    end else begin
      hb1Upd_q   <= cicValid_q && p1_q;
      hb1Valid_q <= hb1Upd_q;
      if (cicValid_q) begin
        hb1Dly_q[0] <= cicOut_q;
        for (int k = 1; k < 6; k++) hb1Dly_q[k] <= hb1Dly_q[k-1];
        p1_q <= ~p1_q;
        if (p1_q) hb1Out_q <= hb1Out_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 10; k++) hb2Dly_q[k] <= '0;
      p2_q       <= 1'b0;
      hb2Out_q   <= '0;
      hb2Upd_q   <= 1'b0;
      hb2Valid_q <= 1'b0;
    end else begin
      hb2Upd_q   <= hb1Valid_q && p2_q;
      hb2Valid_q <= hb2Upd_q;
      if (hb1Valid_q) begin
        hb2Dly_q[0] <= hb1Out_q;
        for (int k = 1; k < 10; k++) hb2Dly_q[k] <= hb2Dly_q[k-1];
        p2_q <= ~p2_q;
        if (p2_q) hb2Out_q <= {{16{hb2Acc[31]}}, hb2Acc};
      end
    end
  end

  assign bus.cic_out   = cicOut_q;
  assign bus.cic_valid = cicValid_q;
  assign bus.hb1_out   = hb1Out_q;
  assign bus.hb1_valid = hb1Valid_q;
  assign bus.hb2_out   = hb2Out_q;
  assign bus.hb2_valid = hb2Valid_q;

endmodule

// File: tb/tb_pdm_decimation_chain.sv
// Bench for pdm_decimation_chain: PDM patterns and random bits, with every strobe
// and decimated sample compared against a convolution model of the filter chain.
module tb_pdm_decimation_chain;
  logic clk;
  logic rst;

  pdm_decimation_chain_if dutIf ();

  pdm_decimation_chain #(.CIC_ORDER(4), .CIC_W(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dutIf.slave)
  );

  int     total  = 0;
  int     bad    = 0;
  int     edgeNo = 0;
  int     xs[$];
  longint kern[61];
  longint hb1Coef[7]  = '{-1, 0, 9, 16, 9, 0, -1};
  longint hb2Coef[11] = '{3, 0, -25, 0, 150, 256, 150, 0, -25, 0, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNo, observed, expected);
    end
  endtask

  // CIC impulse response: a 16-sample boxcar convolved with itself four times.
  function automatic void buildKernel();
    longint tmp[61];
    for (int i = 0; i < 61; i++) kern[i] = (i == 0) ? 1 : 0;
    repeat (4) begin
      for (int i = 0; i < 61; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < 16; j++) if (i - j >= 0) tmp[i] += kern[i-j];
      end
      kern = tmp;
    end
  endfunction

  function automatic longint satRange(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint cicModel(int m);
    longint s;
    int     t;
    s = 0;
    for (int j = 0; j < 61; j++) begin
      t = 16 * m + 15 - j;
      if (t >= 0 && t < xs.size()) s += kern[j] * xs[t];
    end
    return satRange(s - 32768, -32768, 32767);
  endfunction

  function automatic longint hb1Model(int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < 7; k++) if (2 * n + 1 - k >= 0) acc += hb1Coef[k] * cicModel(2 * n + 1 - k);
    return satRange(acc >>> 4, -65536, 65535);
  endfunction

  function automatic longint hb2Model(int q);
    longint acc;
    acc = 0;
    for (int k = 0; k < 11; k++) if (2 * q + 1 - k >= 0) acc += hb2Coef[k] * hb1Model(2 * q + 1 - k);
    return acc;
  endfunction

  function automatic logic genBit(int mode, int idx);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (idx % 2 == 0);
      default: return logic'($urandom & 1);
    endcase
  endfunction

  task automatic checkCycle(input bit wrapCheck);
    bit expC, expH1, expH2;
    expC  = (edgeNo >= 17) && ((edgeNo - 17) % 16 == 0);
    expH1 = (edgeNo >= 35) && ((edgeNo - 35) % 32 == 0);
    expH2 = (edgeNo >= 69) && ((edgeNo - 69) % 64 == 0);
    checkOutput("strobes", {dutIf.cic_valid, dutIf.hb1_valid, dutIf.hb2_valid}, {expC, expH1, expH2});
    if (expC)  checkOutput("cic", dutIf.cic_out, cicModel((edgeNo - 17) / 16));
    if (expH1) checkOutput("hb1", dutIf.hb1_out, hb1Model((edgeNo - 35) / 32));
    if (expH2) checkOutput("hb2", dutIf.hb2_out, hb2Model((edgeNo - 69) / 64));
    if (wrapCheck && expC && edgeNo >= 17 + 48) checkOutput("wrap_cic", dutIf.cic_out, 32767);
  endtask

  task automatic applyStimulus(input int n, input int mode, input bit wrapCheck);
    logic b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b = genBit(mode, xs.size());
      dutIf.pdm_in = b;
      xs.push_back(int'(b));
      @(posedge clk);
      #1;
      edgeNo++;
      checkCycle(wrapCheck);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    dutIf.pdm_in = logic'($urandom & 1);
    @(posedge clk);
    #1;
    checkOutput("rst_cic", dutIf.cic_out, 0);
    checkOutput("rst_hb1", dutIf.hb1_out, 0);
    checkOutput("rst_hb2", dutIf.hb2_out, 0);
    checkOutput("rst_strobes", {dutIf.cic_valid, dutIf.hb1_valid, dutIf.hb2_valid}, 0);
    rst = 1'b0;
    xs.delete();
    edgeNo = 0;
  endtask

  task automatic finalChecks(input string tag, input longint c, input longint h1, input longint h2);
    checkOutput({tag, "_cic"}, dutIf.cic_out, c);
    checkOutput({tag, "_hb1"}, dutIf.hb1_out, h1);
    checkOutput({tag, "_hb2"}, dutIf.hb2_out, h2);
  endtask

  initial begin
    buildKernel();
    rst = 1'b1;
    dutIf.pdm_in = 1'b0;

    doReset();
    applyStimulus(2000, 1, 1'b0);
    finalChecks("ones", 32767, 65534, 33553408);

    doReset();
    applyStimulus(600, 0, 1'b0);
    finalChecks("zeros", -32768, -65536, -33554432);

    doReset();
    applyStimulus(600, 2, 1'b0);
    finalChecks("alt", 0, 0, 0);

    $display("[TB] random stream, then reset landing on a CIC decimation edge");
    doReset();
    applyStimulus(1503, 3, 1'b0);
    doReset();
    applyStimulus(4000, 1, 1'b1);
    finalChecks("rerun", 32767, 65534, 33553408);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
